// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one SDRAM controller burst port among three
// requesters. Grants are round-robin and held for a full 4-word line. Each
// burst is followed by a one-cycle release gap, and a watchdog aborts any
// burst that the controller does not finish.
module sdram_port_arbiter #(
  parameter int unsigned ADDR_W  = 24,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          m_req,
  input  logic [2:0]          m_wren,
  input  logic [3*ADDR_W-1:0] m_address,
  input  logic [47:0]         m_to_mem,
  output logic [2:0]          m_ready,
  output logic [1:0]          m_offset,
  output logic                s_req,
  output logic                s_wren,
  output logic [ADDR_W-1:0]   s_address,
  output logic [15:0]         s_to_mem,
  input  logic                s_ready,
  input  logic [1:0]          s_offset,
  output logic [2:0]          grant,
  output logic                busy,
  output logic                err,
  input  logic                err_clr
);

  localparam int unsigned NREQ   = 3;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned WD_W   = 8;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      grant_q, grant_d;
  logic [1:0]      last_q, last_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;

  logic [1:0]      win_idx;
  logic [1:0]      cand;
  logic            final_word;

  assign final_word = s_ready && (s_offset == 2'd3);

  // Round-robin search starting after the last owner; nearest candidate wins.
  always_comb begin
    win_idx = last_q;
    cand    = 2'd0;
    for (int unsigned k = 3; k >= 1; k--) begin
      cand = 2'((32'(last_q) + k) % 32'd3);
      if (m_req[cand]) win_idx = cand;
    end
  end

  // State, grant, round-robin pointer, watchdog and error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 3'b000;
      last_q  <= 2'd2;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: arbitrate in IDLE, run the burst with watchdog, then release.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    wd_d    = wd_q;
    err_d   = err_clr ? 1'b0 : err_q;
    unique case (state_q)
      IDLE: begin
        if (|m_req) begin
          state_d = BUSY;
          grant_d = 3'b001 << win_idx;
          last_d  = win_idx;
          wd_d    = '0;
        end
      end
      BUSY: begin
        wd_d = wd_q + WD_W'(1);
        if (final_word) begin
          state_d = RELEASE;
          grant_d = 3'b000;
        end else if (wd_q == WD_LAST) begin
          // Controller stalled: abort; undelivered words are dropped.
          state_d = RELEASE;
          grant_d = 3'b000;
          err_d   = 1'b1;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        grant_d = 3'b000;
      end
      default: begin
        state_d = IDLE;
        grant_d = 3'b000;
      end
    endcase
  end

  // Owner's request fields steered to the controller; zero when no burst is active.
  always_comb begin
    s_wren    = 1'b0;
    s_address = '0;
    s_to_mem  = '0;
    if (state_q == BUSY) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (grant_q[i]) begin
          s_wren    = m_wren[i];
          s_address = m_address[i*ADDR_W +: ADDR_W];
          s_to_mem  = m_to_mem[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign s_req    = (state_q == BUSY);
  assign busy     = (state_q == BUSY);
  assign m_ready  = (state_q == BUSY) ? (grant_q & {3{s_ready}}) : 3'b000;
  assign m_offset = s_offset;
  assign grant    = grant_q;
  assign err      = err_q;

endmodule
